mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory bus port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, after byte-lane/strobe generation).
- Supports one outstanding transaction at a time and registers the winning request.
- Drives the bus handshake through an FSM and routes the response back to the owner only.
- Data wins by default; a starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  32  fetch address (word-aligned)
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wstrb  in  4  store byte enables
- data_wdata  in  32  store data, lane-replicated
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  raw load word, before extraction
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  32  bus address
- bus_wstrb  out  4  bus byte enables
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  bus accepted the request
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  32  bus read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ADDR, WAIT.
- Reset (resetn=0, async):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All registered bus fields cleared.
  - All outputs 0.
  - An in-flight bus transaction is abandoned; the bus slave shares resetn.
- IDLE, arbitration:
  - Grant goes to data if data_req && !(inst_req && starve_cnt==STARVE_LIMIT); otherwise to inst if inst_req.
  - The winner's addr_ok=1 combinationally in this cycle.
  - Request fields are latched: inst grants latch wr=0, size=2, wstrb=0, wdata=0.
  - owner is set, next state is ADDR.
  - The loser gets addr_ok=0 and must hold its req.
  - addr_ok is never asserted outside IDLE.
- starve_cnt update, on each IDLE grant:
  - Data grant while inst_req=1: increment, saturating at STARVE_LIMIT.
  - Any inst grant: clear to 0.
  - Data grant with inst_req=0: clear to 0.
- ADDR:
  - bus_req=1 with the latched fields, held stable until bus_addr_ok=1.
  - On bus_addr_ok && !bus_data_ok: go to WAIT.
  - On bus_addr_ok && bus_data_ok in the same cycle: owner data_ok=1 and rdata=bus_rdata that cycle, then go to IDLE.
- WAIT:
  - bus_req=0.
  - On bus_data_ok: owner data_ok=1 and rdata=bus_rdata (combinational pass-through), then go to IDLE.
- Response routing: the non-owner's data_ok is always 0, and its rdata is 0.
- Spurious input: bus_data_ok in IDLE or ADDR (without bus_addr_ok) is ignored.
- Latency: minimum 2 cycles from accept to data_ok (accept in IDLE, addr and data handshake in ADDR). A new request can be accepted in the cycle after data_ok.
- Both requests in the same cycle:
  - Data wins unless the starvation limit has been reached.
  - With STARVE_LIMIT=4, fetch is guaranteed a grant after at most 4 consecutive data grants.
- Not checked here: size/wstrb consistency and address alignment. Address-error detection belongs to the MEM stage.

Decomposition:
- Shared package/defines header holds:
  - FSM state encodings ST_IDLE/ST_ADDR/ST_WAIT (2 bits)
  - owner encodings OWN_NONE/OWN_INST/OWN_DATA
  - size encodings SIZE_B/SIZE_H/SIZE_W
- Sub-module mem_arb_pick: combinational grant selection from inst_req, data_req and starve_cnt.
- FSM, latch registers and routing stay in the top.

Test Plan:
- Single fetch:
  - Stimulus: inst_req=1, addr=0xBFC00000; bus_addr_ok 1 cycle later; bus_data_ok 2 cycles after that with rdata=0x3C1D8000.
  - Required: inst_addr_ok in cycle 0; bus_addr=0xBFC00000, bus_wr=0; inst_data_ok for 1 cycle with 0x3C1D8000; data_data_ok=0 throughout.
- Byte store:
  - Stimulus: data_req=1, wr=1, size=0, addr=0x80000003, wstrb=0x8, wdata=0xABABABAB; zero-wait bus (addr_ok and data_ok together).
  - Required: bus fields match the inputs; data_data_ok exactly 2 cycles after accept.
- Simultaneous requests:
  - Stimulus: inst_req and data_req both high in IDLE.
  - Required: data_addr_ok=1, inst_addr_ok=0; fetch is granted in the IDLE cycle after the data response.
- Starvation:
  - Stimulus: inst_req and data_req held high continuously, STARVE_LIMIT=4.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I.
- Reset mid-transaction:
  - Stimulus: drop resetn while in WAIT.
  - Required: bus_req, busy and both data_ok outputs are 0 immediately (async); a request after reset is serviced normally.
- Stall on bus:
  - Stimulus: bus_addr_ok held low for 5 cycles.
  - Required: bus_req and bus_addr stay stable all 5 cycles; no addr_ok is asserted to either requester during that time.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection, data first unless fetch is starved
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       inst_req,
    input  logic       data_req,
    input  logic [3:0] starve_cnt,
    output logic       grant_inst,
    output logic       grant_data
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    // data wins by default; a starved fetch takes the port instead
    always_comb begin
        grant_data = data_req && !(inst_req && starve_cnt == LIMIT);
        grant_inst = inst_req && !grant_data;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus port between fetch and data requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nx;
    owner_t     owner;
    logic [3:0] starve_cnt;
    logic       grant_inst, grant_data, done;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve_cnt (starve_cnt),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // accepts only in IDLE (and never during reset); the response goes to the owner alone
    always_comb begin
        inst_addr_ok = resetn && state == ST_IDLE && grant_inst;
        data_addr_ok = resetn && state == ST_IDLE && grant_data;
        done         = (state == ST_ADDR && bus_addr_ok && bus_data_ok) || (state == ST_WAIT && bus_data_ok);
        inst_data_ok = done && owner == OWN_INST;
        data_data_ok = done && owner == OWN_DATA;
        inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
        data_rdata   = data_data_ok ? bus_rdata : 32'd0;
        bus_req      = state == ST_ADDR;
        busy         = state != ST_IDLE;
    end

    // next state: accept -> address phase -> optional wait for response
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = (inst_addr_ok || data_addr_ok) ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_nx = bus_addr_ok ? (bus_data_ok ? ST_IDLE : ST_WAIT) : ST_ADDR;
            ST_WAIT: state_nx = bus_data_ok ? ST_IDLE : ST_WAIT;
            default: state_nx = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // latch the winning request, track ownership and fetch starvation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            bus_wr     <= 1'b0;
            bus_size   <= 2'd0;
            bus_addr   <= 32'd0;
            bus_wstrb  <= 4'd0;
            bus_wdata  <= 32'd0;
        end else if (data_addr_ok) begin
            owner      <= OWN_DATA;
            starve_cnt <= inst_req ? ((starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1) : 4'd0;
            bus_wr     <= data_wr;
            bus_size   <= data_size;
            bus_addr   <= data_addr;
            bus_wstrb  <= data_wstrb;
            bus_wdata  <= data_wdata;
        end else if (inst_addr_ok) begin
            owner      <= OWN_INST;
            starve_cnt <= 4'd0;
            bus_wr     <= 1'b0;
            bus_size   <= SIZE_W;
            bus_addr   <= inst_addr;
            bus_wstrb  <= 4'd0;
            bus_wdata  <= 32'd0;
        end else if (done) begin
            owner      <= OWN_NONE;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus checked against a transaction-level model
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    localparam byte GD = 8'h44;
    localparam byte GI = 8'h49;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        inst_req = 0, data_req = 0, data_wr = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, bus_rdata = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic        bus_addr_ok = 0, bus_data_ok = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        bus_req, bus_wr, busy;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;

    int tests = 0, fails = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // transaction-level model: one transaction in flight, its fields, and the data-win streak
    bit          m_pend, m_addr_done, m_is_data;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic        m_wr;
    bit          e_gd, e_gi, e_fin;
    byte         glog[$];

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_busy", busy, 0);
            chk("rst_bus_req", bus_req, 0);
            chk("rst_inst_addr_ok", inst_addr_ok, 0);
            chk("rst_data_addr_ok", data_addr_ok, 0);
            chk("rst_inst_data_ok", inst_data_ok, 0);
            chk("rst_data_data_ok", data_data_ok, 0);
            m_pend = 0;
            m_addr_done = 0;
            m_streak = 0;
        end else begin
            e_gd  = !m_pend && data_req && !(inst_req && m_streak == LIMIT);
            e_gi  = !m_pend && inst_req && !e_gd;
            e_fin = m_pend && bus_data_ok && (m_addr_done || bus_addr_ok);
            chk("busy", busy, m_pend);
            chk("inst_addr_ok", inst_addr_ok, e_gi);
            chk("data_addr_ok", data_addr_ok, e_gd);
            chk("bus_req", bus_req, m_pend && !m_addr_done);
            chk("inst_data_ok", inst_data_ok, e_fin && !m_is_data);
            chk("data_data_ok", data_data_ok, e_fin && m_is_data);
            chk("inst_rdata", inst_rdata, (e_fin && !m_is_data) ? bus_rdata : 32'd0);
            chk("data_rdata", data_rdata, (e_fin && m_is_data) ? bus_rdata : 32'd0);
            if (m_pend && !m_addr_done) begin
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_wr", bus_wr, m_wr);
                chk("bus_size", bus_size, m_size);
                chk("bus_wstrb", bus_wstrb, m_wstrb);
                chk("bus_wdata", bus_wdata, m_wdata);
            end
            if (e_fin) m_pend = 0;
            else if (m_pend && bus_addr_ok) m_addr_done = 1;
            if (e_gd || e_gi) begin
                glog.push_back(e_gd ? GD : GI);
                m_streak = (e_gd && inst_req) ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
                m_pend = 1;
                m_addr_done = 0;
                m_is_data = e_gd;
                m_addr  = e_gd ? data_addr : inst_addr;
                m_wr    = e_gd ? data_wr : 1'b0;
                m_size  = e_gd ? data_size : 2'd2;
                m_wstrb = e_gd ? data_wstrb : 4'd0;
                m_wdata = e_gd ? data_wdata : 32'd0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_seq;
        exp_seq = "DDDDIDDDDI";
        cyc(); cyc();
        chk("reset_bus_addr", bus_addr, 32'd0);
        chk("reset_busy", busy, 0);
        resetn = 1;
        cyc();

        // single fetch with one wait cycle between address and data
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1 chk("fetch_accept", inst_addr_ok, 1);
        cyc();
        inst_req = 0; bus_addr_ok = 1;
        #1 chk("fetch_bus_addr", bus_addr, 32'hBFC00000);
        chk("fetch_bus_wr", bus_wr, 0);
        chk("fetch_bus_req", bus_req, 1);
        cyc();
        bus_addr_ok = 0;
        #1 chk("fetch_wait_no_ok", inst_data_ok, 0);
        cyc();
        bus_data_ok = 1; bus_rdata = 32'h3C1D8000;
        #1 chk("fetch_data_ok", inst_data_ok, 1);
        chk("fetch_rdata", inst_rdata, 32'h3C1D8000);
        chk("fetch_no_data_ok", data_data_ok, 0);
        cyc();
        bus_data_ok = 0;
        #1 chk("fetch_done_ok_low", inst_data_ok, 0);
        chk("fetch_done_idle", busy, 0);

        // byte store on a zero-wait bus
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h80000003;
        data_wstrb = 4'h8; data_wdata = 32'hABABABAB;
        #1 chk("store_accept", data_addr_ok, 1);
        cyc();
        data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h11223344;
        #1 chk("store_bus_addr", bus_addr, 32'h80000003);
        chk("store_bus_wr", bus_wr, 1);
        chk("store_bus_size", bus_size, 0);
        chk("store_bus_wstrb", bus_wstrb, 4'h8);
        chk("store_bus_wdata", bus_wdata, 32'hABABABAB);
        chk("store_data_ok", data_data_ok, 1);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 0; data_wr = 0;
        #1 chk("store_done_ok_low", data_data_ok, 0);

        // simultaneous requests: data first, fetch right after the response
        inst_req = 1; inst_addr = 32'hBFC00004; data_req = 1; data_size = 2'd2; data_addr = 32'h80000100;
        #1 chk("sim_data_wins", data_addr_ok, 1);
        chk("sim_inst_loses", inst_addr_ok, 0);
        cyc();
        data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0000BEEF;
        #1 chk("sim_inst_held_off", inst_addr_ok, 0);
        chk("sim_data_resp", data_data_ok, 1);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 0;
        #1 chk("sim_inst_granted", inst_addr_ok, 1);
        cyc();
        inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h24080001;
        #1 chk("sim_inst_resp", inst_rdata, 32'h24080001);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 0;

        // bus stall: request fields held, no accepts while busy
        data_req = 1; data_addr = 32'h80001234;
        #1 chk("stall_accept", data_addr_ok, 1);
        cyc();
        inst_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_bus_req", bus_req, 1);
            chk("stall_bus_addr", bus_addr, 32'h80001234);
            chk("stall_no_inst_ok", inst_addr_ok, 0);
            chk("stall_no_data_ok", data_addr_ok, 0);
            cyc();
        end
        inst_req = 0; data_req = 0; bus_addr_ok = 1;
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h55AA55AA;
        #1 chk("stall_resp", data_rdata, 32'h55AA55AA);
        cyc();
        bus_data_ok = 0;

        // reset while waiting for the response
        inst_req = 1; inst_addr = 32'hBFC00010;
        cyc();
        inst_req = 0; bus_addr_ok = 1;
        cyc();
        bus_addr_ok = 0;
        cyc();
        bus_data_ok = 1; inst_req = 1; resetn = 0;
        #1 chk("arst_bus_req", bus_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_inst_data_ok", inst_data_ok, 0);
        chk("arst_data_data_ok", data_data_ok, 0);
        chk("arst_inst_addr_ok", inst_addr_ok, 0);
        cyc();
        bus_data_ok = 0; inst_req = 0;
        cyc();
        resetn = 1; data_req = 1; data_addr = 32'h80000010; data_size = 2'd2;
        #1 chk("post_rst_accept", data_addr_ok, 1);
        cyc();
        data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h12345678;
        #1 chk("post_rst_resp", data_rdata, 32'h12345678);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 0;

        // starvation: both requests held against a zero-wait bus
        resetn = 0;
        cyc();
        resetn = 1; glog.delete();
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFE0000;
        for (int i = 0; i < 20; i++) cyc();
        inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        cyc(); cyc();
        chk("starve_len", glog.size(), 10);
        for (int i = 0; i < 10 && i < glog.size(); i++) chk("starve_seq", glog[i], exp_seq[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
